cpu_debug_monitor: RTL and testbench

CPU_DEBUG_MONITOR -- requirements
Module: cpu_debug_monitor

---
 rtl/cpu_debug_pkg.sv | 20 ++
 rtl/debug_fifo.sv | 54 +++++
 rtl/cpu_debug_monitor.sv | 120 ++++++++++++
 tb/tb_cpu_debug_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared run-state encoding and default sizing for the CPU debug monitor.
package cpu_debug_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 16;
  localparam int unsigned DEF_PC_SIZE    = 8;
  localparam int unsigned DEF_NUM_REGS   = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  // Register-select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_fifo.sv
// WWD capture FIFO: power-of-two depth, drop-on-full push, ignore-on-empty pop.
module debug_fifo #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uncleared on reset.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_debug_monitor.sv
// CPU debug monitor: run/halt/single-step gating, retire counter, PC tap,
// and a display mux over the WWD capture FIFO or a selected register.
module cpu_debug_monitor
  import cpu_debug_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned PC_SIZE    = DEF_PC_SIZE,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned SEL_WIDTH = sel_width(NUM_REGS),
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset_cpu,
  input  logic                          cpu_enable,
  input  logic                          step_req,
  output logic                          run_gate,
  input  logic                          inst_retire,
  input  logic [WORD_SIZE-1:0]          pc,
  input  logic                          wwd_valid,
  input  logic [WORD_SIZE-1:0]          wwd_data,
  input  logic                          wwd_enable,
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_snapshot,
  input  logic [SEL_WIDTH-1:0]          register_selection,
  input  logic                          pop,
  output logic [WORD_SIZE-1:0]          num_inst,
  output logic [WORD_SIZE-1:0]          output_port,
  output logic [PC_SIZE-1:0]            pc_low,
  output logic [CNT_WIDTH-1:0]          fifo_count,
  output logic                          overflow
);

  run_state_e           state;
  logic                 step_prev;
  logic                 step_edge;
  logic [WORD_SIZE-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] sel_val_c;
  logic [WORD_SIZE-1:0] display_c;
  logic                 unused_pc;

  assign step_edge = step_req & ~step_prev;
  assign unused_pc = ^pc;

  debug_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset_cpu),
    .push (wwd_valid),
    .pop  (pop),
    .din  (wwd_data),
    .head (fifo_head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Out-of-range selections fall through to zero.
  always_comb begin
    sel_val_c = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (register_selection == SEL_WIDTH'(k)) sel_val_c = reg_snapshot[k*WORD_SIZE +: WORD_SIZE];
    end
    display_c = wwd_enable ? (fifo_empty ? '0 : fifo_head) : sel_val_c;
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state       <= ST_HALT;
      run_gate    <= 1'b0;
      step_prev   <= 1'b0;
      num_inst    <= '0;
      pc_low      <= '0;
      output_port <= '0;
      overflow    <= 1'b0;
    end else begin
      step_prev   <= step_req;
      pc_low      <= pc[PC_SIZE-1:0];
      output_port <= display_c;
      if (inst_retire) num_inst <= num_inst + WORD_SIZE'(1);
      if (wwd_valid && fifo_full && !pop) overflow <= 1'b1;

      // run_gate is updated alongside the state so it mirrors it without decode glitches.
      case (state)
        ST_HALT: begin
          if (cpu_enable) begin
            state    <= ST_RUN;
            run_gate <= 1'b1;
          end else if (step_edge) begin
            state    <= ST_STEP;
            run_gate <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!cpu_enable) begin
            state    <= ST_HALT;
            run_gate <= 1'b0;
          end
        end
        ST_STEP: begin
          if (cpu_enable) begin
            state    <= ST_RUN;
            run_gate <= 1'b1;
          end else if (inst_retire) begin
            state    <= ST_HALT;
            run_gate <= 1'b0;
          end
        end
        default: begin
          state    <= ST_HALT;
          run_gate <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Self-checking bench for cpu_debug_monitor at default parameters.
module tb_cpu_debug_monitor;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic        cpu_enable;
  logic        step_req;
  logic        run_gate;
  logic        inst_retire;
  logic [15:0] pc;
  logic        wwd_valid;
  logic [15:0] wwd_data;
  logic        wwd_enable;
  logic [63:0] reg_snapshot;
  logic [1:0]  register_selection;
  logic        pop;
  logic [15:0] num_inst;
  logic [15:0] output_port;
  logic [7:0]  pc_low;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_q[$];

  always #5 clk = ~clk;

  cpu_debug_monitor dut (
    .clk               (clk),
    .reset_cpu         (reset_cpu),
    .cpu_enable        (cpu_enable),
    .step_req          (step_req),
    .run_gate          (run_gate),
    .inst_retire       (inst_retire),
    .pc                (pc),
    .wwd_valid         (wwd_valid),
    .wwd_data          (wwd_data),
    .wwd_enable        (wwd_enable),
    .reg_snapshot      (reg_snapshot),
    .register_selection(register_selection),
    .pop               (pop),
    .num_inst          (num_inst),
    .output_port       (output_port),
    .pc_low            (pc_low),
    .fifo_count        (fifo_count),
    .overflow          (overflow)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    cpu_enable         = 1'b0;
    step_req           = 1'b0;
    inst_retire        = 1'b0;
    pc                 = 16'h0000;
    wwd_valid          = 1'b0;
    wwd_data           = 16'h0000;
    wwd_enable         = 1'b0;
    reg_snapshot       = 64'h0;
    register_selection = 2'd0;
    pop                = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_cpu = 1'b1;
    tick(2);
    reset_cpu = 1'b0;
    model_q.delete();
    tick();
  endtask

  task automatic test_reset();
    reset_cpu   = 1'b1;
    cpu_enable  = 1'b1;
    step_req    = 1'b1;
    inst_retire = 1'b1;
    pc          = 16'h1234;
    wwd_valid   = 1'b1;
    wwd_data    = 16'h5A5A;
    wwd_enable  = 1'b1;
    pop         = 1'b1;
    tick(10);
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL reset_run_gate: got %0h want 0", run_gate); end
    n_cmp++; if (num_inst !== 16'h0) begin n_err++; $display("FAIL reset_num_inst: got %0h want 0", num_inst); end
    n_cmp++; if (output_port !== 16'h0) begin n_err++; $display("FAIL reset_output_port: got %0h want 0", output_port); end
    n_cmp++; if (pc_low !== 8'h0) begin n_err++; $display("FAIL reset_pc_low: got %0h want 0", pc_low); end
    n_cmp++; if (fifo_count !== 4'h0) begin n_err++; $display("FAIL reset_fifo_count: got %0h want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    idle_inputs();
    reset_cpu = 1'b0;
    model_q.delete();
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL post_reset_halt: got %0h want 0", run_gate); end
  endtask

  task automatic test_run();
    cpu_enable = 1'b1;
    tick();
    n_cmp++; if (run_gate !== 1'b1) begin n_err++; $display("FAIL run_gate_on: got %0h want 1", run_gate); end
    inst_retire = 1'b1;
    tick(5);
    inst_retire = 1'b0;
    tick();
    n_cmp++; if (num_inst !== 16'd5) begin n_err++; $display("FAIL run_num_inst: got %0h want 5", num_inst); end
    // Step edge while running must not be remembered once halted.
    step_req = 1'b1;
    tick();
    cpu_enable = 1'b0;
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL run_to_halt: got %0h want 0", run_gate); end
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL run_edge_ignored: got %0h want 0", run_gate); end
    step_req = 1'b0;
    tick();
  endtask

  task automatic test_step();
    int gate_cnt = 0;
    step_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (run_gate === 1'b1) gate_cnt++;
      inst_retire = (i == 2);
      if (i == 3) step_req = 1'b0;
    end
    n_cmp++; if (gate_cnt != 3) begin n_err++; $display("FAIL step_gate_cycles: got %0d want 3", gate_cnt); end
    n_cmp++; if (num_inst !== 16'd6) begin n_err++; $display("FAIL step_num_inst: got %0h want 6", num_inst); end
    step_req = 1'b1;
    tick();
    n_cmp++; if (run_gate !== 1'b1) begin n_err++; $display("FAIL step2_gate: got %0h want 1", run_gate); end
    inst_retire = 1'b1;
    tick();
    inst_retire = 1'b0;
    step_req    = 1'b0;
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL step2_halt: got %0h want 0", run_gate); end
    tick();
    // Enable wins over a same-cycle retire while stepping.
    step_req = 1'b1;
    tick();
    cpu_enable  = 1'b1;
    inst_retire = 1'b1;
    tick();
    inst_retire = 1'b0;
    step_req    = 1'b0;
    tick();
    n_cmp++; if (run_gate !== 1'b1) begin n_err++; $display("FAIL step_enable_priority: got %0h want 1", run_gate); end
    cpu_enable = 1'b0;
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL step_final_halt: got %0h want 0", run_gate); end
    n_cmp++; if (num_inst !== 16'd8) begin n_err++; $display("FAIL step_final_num_inst: got %0h want 8", num_inst); end
  endtask

  task automatic drain_and_check(input int n, input string tag);
    logic [15:0] want;
    for (int i = 0; i < n; i++) begin
      pop = 1'b1;
      if (model_q.size() > 0) void'(model_q.pop_front());
      exp_q.push_back(model_q.size() > 0 ? model_q[0] : 16'h0000);
      tick();
      pop = 1'b0;
      tick();
      want = exp_q.pop_front();
      n_cmp++; if (output_port !== want) begin n_err++; $display("FAIL %s_pop%0d: got %04h want %04h", tag, i, output_port, want); end
    end
  endtask

  task automatic test_fifo_overflow();
    logic ov_exp = 1'b0;
    wwd_enable = 1'b1;
    for (int v = 1; v <= 9; v++) begin
      wwd_valid = 1'b1;
      wwd_data  = 16'(v);
      if (model_q.size() < 8) model_q.push_back(16'(v));
      else ov_exp = 1'b1;
      tick();
    end
    wwd_valid = 1'b0;
    tick();
    n_cmp++; if (fifo_count !== 4'(model_q.size())) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, model_q.size()); end
    n_cmp++; if (overflow !== ov_exp) begin n_err++; $display("FAIL ovf_flag: got %0h want %0h", overflow, ov_exp); end
    n_cmp++; if (output_port !== model_q[0]) begin n_err++; $display("FAIL ovf_head: got %04h want %04h", output_port, model_q[0]); end
    drain_and_check(9, "ovf");
    n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL ovf_drained_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    wwd_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wwd_valid = 1'b1;
      wwd_data  = 16'h0100 + 16'(i);
      model_q.push_back(wwd_data);
      tick();
    end
    wwd_valid = 1'b1;
    wwd_data  = 16'hBEEF;
    pop       = 1'b1;
    void'(model_q.pop_front());
    model_q.push_back(16'hBEEF);
    tick();
    wwd_valid = 1'b0;
    pop       = 1'b0;
    tick();
    n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL full_pp_count: got %0d want 8", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow: got %0h want 0", overflow); end
    n_cmp++; if (output_port !== model_q[0]) begin n_err++; $display("FAIL full_pp_head: got %04h want %04h", output_port, model_q[0]); end
    drain_and_check(8, "full_pp");
    // Push+pop on empty performs the push only.
    wwd_valid = 1'b1;
    wwd_data  = 16'h7777;
    pop       = 1'b1;
    tick();
    wwd_valid = 1'b0;
    pop       = 1'b0;
    tick();
    n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL empty_pp_count: got %0d want 1", fifo_count); end
    n_cmp++; if (output_port !== 16'h7777) begin n_err++; $display("FAIL empty_pp_head: got %04h want 7777", output_port); end
  endtask

  task automatic test_reg_select();
    logic [15:0] want;
    wwd_enable   = 1'b0;
    reg_snapshot = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int s = 0; s < 4; s++) begin
      register_selection = 2'(s);
      pc = 16'hA0B0 + 16'(s);
      exp_q.push_back(16'h1111 * 16'(s + 1));
      tick();
      want = exp_q.pop_front();
      n_cmp++; if (output_port !== want) begin n_err++; $display("FAIL regsel%0d: got %04h want %04h", s, output_port, want); end
      n_cmp++; if (pc_low !== 8'hB0 + 8'(s)) begin n_err++; $display("FAIL pc_low%0d: got %02h want %02h", s, pc_low, 8'hB0 + 8'(s)); end
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    inst_retire = 1'b1;
    tick(65535);
    n_cmp++; if (num_inst !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %04h want ffff", num_inst); end
    tick();
    inst_retire = 1'b0;
    n_cmp++; if (num_inst !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %04h want 0000", num_inst); end
    wwd_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wwd_valid = 1'b1;
      wwd_data  = 16'hC000 + 16'(i);
      tick();
    end
    wwd_valid   = 1'b0;
    inst_retire = 1'b1;
    tick();
    inst_retire = 1'b0;
    step_req    = 1'b1;
    pc          = 16'h55AA;
    tick();
    n_cmp++; if (run_gate !== 1'b1) begin n_err++; $display("FAIL midstep_entered: got %0h want 1", run_gate); end
    reset_cpu   = 1'b1;
    wwd_valid   = 1'b1;
    inst_retire = 1'b1;
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL midstep_rst_gate: got %0h want 0", run_gate); end
    n_cmp++; if (num_inst !== 16'h0) begin n_err++; $display("FAIL midstep_rst_num_inst: got %04h want 0", num_inst); end
    n_cmp++; if (output_port !== 16'h0) begin n_err++; $display("FAIL midstep_rst_output: got %04h want 0", output_port); end
    n_cmp++; if (pc_low !== 8'h0) begin n_err++; $display("FAIL midstep_rst_pc_low: got %02h want 0", pc_low); end
    n_cmp++; if (fifo_count !== 4'h0) begin n_err++; $display("FAIL midstep_rst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midstep_rst_overflow: got %0h want 0", overflow); end
    idle_inputs();
    reset_cpu = 1'b0;
    tick();
    n_cmp++; if (run_gate !== 1'b0) begin n_err++; $display("FAIL post_midstep_gate: got %0h want 0", run_gate); end
  endtask

  initial begin
    idle_inputs();
    reset_cpu = 1'b1;
    test_reset();
    test_run();
    test_step();
    test_fifo_overflow();
    test_push_pop_full();
    test_reg_select();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
